// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read 64-bit memory port between
// four requesters, with locked bursts capped at MAX_LOCK beats.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_LOCK   = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [3:0]              req,
  input  logic [3:0]              we,
  input  logic [3:0]              lock,
  input  logic [4*ADDR_WIDTH-1:0] addr,
  input  logic [255:0]            wdata,
  output logic [3:0]              gnt,
  output logic [3:0]              rd_valid,
  output logic [63:0]             rd_data,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wr_en,
  output logic [63:0]             mem_wr_data,
  input  logic [63:0]             mem_rd_data
);

  localparam logic [0:0] ST_FREE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam int         CW        = $clog2(MAX_LOCK + 1);

  logic [0:0]    state;
  logic [1:0]    ptr;
  logic [1:0]    owner;
  logic [CW-1:0] beat_cnt;
  logic          no_relock;

  logic       gnt_any;
  logic [1:0] gnt_idx;
  logic [1:0] cand;
  logic       eff_lock;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    if (state == ST_FREE) begin
      for (int k = 0; k < 4; k++) begin
        cand = ptr + 2'(k);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end else if (req[owner]) begin
      gnt_any = 1'b1;
      gnt_idx = owner;
    end
  end

  // After a capped burst the former owner's lock is ignored once it wins again.
  assign eff_lock = lock[gnt_idx] && !(no_relock && gnt_idx == owner);

  assign gnt         = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
  assign mem_addr    = gnt_any ? addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_wr_en   = gnt_any && we[gnt_idx];
  assign mem_wr_data = gnt_any ? wdata[gnt_idx*64 +: 64] : 64'd0;
  assign rd_data     = mem_rd_data;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_FREE;
      ptr       <= 2'd0;
      owner     <= 2'd0;
      beat_cnt  <= '0;
      no_relock <= 1'b0;
      rd_valid  <= 4'b0000;
    end else begin
      rd_valid <= (gnt_any && !we[gnt_idx]) ? gnt : 4'b0000;
      if (state == ST_FREE) begin
        if (gnt_any) begin
          no_relock <= 1'b0;
          if (eff_lock) begin
            state    <= ST_LOCKED;
            owner    <= gnt_idx;
            beat_cnt <= CW'(1);
          end else begin
            ptr <= gnt_idx + 2'd1;
          end
        end
      end else begin
        if (!req[owner] || !lock[owner]) begin
          // Owner dropped its request or issued its final beat.
          state    <= ST_FREE;
          ptr      <= owner + 2'd1;
          beat_cnt <= '0;
        end else if (beat_cnt == CW'(MAX_LOCK - 1)) begin
          state     <= ST_FREE;
          ptr       <= owner + 2'd1;
          beat_cnt  <= '0;
          no_relock <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants checked per cycle, read returns
// checked by a scoreboard monitor against a bench-side memory model.
module tb_mem_port_arbiter;

  localparam int AW = 12;

  logic          clk;
  logic          rstn;
  logic [3:0]    req, we, lock;
  logic [4*AW-1:0] addr;
  logic [255:0]  wdata;
  logic [3:0]    gnt, rd_valid;
  logic [63:0]   rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [63:0]   mem_wr_data, mem_rd_data;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MAX_LOCK(16)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mem     [0:4095];
  logic [63:0] exp_mem [0:4095];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
  end

  typedef struct {
    int          due;
    logic [3:0]  port;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [AW-1:0] ra [4];
  logic [63:0]   rw [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read-return monitor, decoupled from stimulus.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("rd_valid", {60'd0, rd_valid}, {60'd0, e.port});
      check("rd_data", rd_data, e.data);
    end else begin
      check("rd_valid_idle", {60'd0, rd_valid}, 64'd0);
    end
  end

  // One arbitration cycle: drive at posedge+1, check combinational outputs at negedge.
  task automatic cycle(input string name, input logic [3:0] rq, input logic [3:0] w,
                       input logic [3:0] lk, input logic [3:0] eg);
    int   idx;
    exp_t e;
    req  = rq;
    we   = w;
    lock = lk;
    for (int i = 0; i < 4; i++) begin
      addr[i*AW +: AW] = ra[i];
      wdata[i*64 +: 64] = rw[i];
    end
    @(negedge clk);
    check({name, "_gnt"}, {60'd0, gnt}, {60'd0, eg});
    if (eg != 4'b0000) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (eg[i]) idx = i;
      check({name, "_mem_wr_en"}, {63'd0, mem_wr_en}, {63'd0, w[idx]});
      check({name, "_mem_addr"}, {52'd0, mem_addr}, {52'd0, ra[idx]});
      if (w[idx]) begin
        check({name, "_mem_wr_data"}, mem_wr_data, rw[idx]);
        exp_mem[ra[idx]] = rw[idx];
      end else begin
        e.due  = cyc + 1;
        e.port = eg;
        e.data = exp_mem[ra[idx]];
        sb.push_back(e);
      end
    end else begin
      check({name, "_idle_wr_en"}, {63'd0, mem_wr_en}, 64'd0);
      check({name, "_idle_addr"}, {52'd0, mem_addr}, 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = 4'b0000;
    lock = 4'b0000;
    sb.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 64'hA5A5_0000_0000_0000 | 64'(i * 3 + 1);
      exp_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 3 + 1);
    end
    for (int i = 0; i < 4; i++) begin
      ra[i] = '0;
      rw[i] = '0;
    end
    rstn  = 1'b0;
    req   = 4'b1111;
    we    = 4'b0000;
    lock  = 4'b0000;
    addr  = '0;
    wdata = '0;

    // Reset: combinational grant follows req, no read return.
    @(posedge clk);
    #1;
    check("rst_gnt", {60'd0, gnt}, 64'h1);
    check("rst_rd_valid", {60'd0, rd_valid}, 64'd0);
    check("rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Basic read.
    ra[0] = 12'h005;
    cycle("basic", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    cycle("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Round-robin fairness.
    do_reset();
    for (int i = 0; i < 4; i++) ra[i] = AW'(12'h020 + i);
    cycle("rr0", 4'b1111, 4'b0000, 4'b0000, 4'b0001);
    cycle("rr1", 4'b1111, 4'b0000, 4'b0000, 4'b0010);
    cycle("rr2", 4'b1111, 4'b0000, 4'b0000, 4'b0100);
    cycle("rr3", 4'b1111, 4'b0000, 4'b0000, 4'b1000);
    cycle("rr4", 4'b1111, 4'b0000, 4'b0000, 4'b0001);
    cycle("rr_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Write then read back.
    ra[2] = 12'h010;
    rw[2] = 64'hDEADBEEF_00000001;
    cycle("wr", 4'b0100, 4'b0100, 4'b0000, 4'b0100);
    ra[0] = 12'h010;
    cycle("rd_after_wr", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    cycle("wr_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Locked burst of 4 beats from requester 1 while requester 0 waits.
    do_reset();
    ra[1] = 12'h050;
    ra[0] = 12'h060;
    cycle("lk0", 4'b0010, 4'b0000, 4'b0010, 4'b0010);
    cycle("lk1", 4'b0011, 4'b0000, 4'b0010, 4'b0010);
    cycle("lk2", 4'b0011, 4'b0000, 4'b0010, 4'b0010);
    cycle("lk3_final", 4'b0011, 4'b0000, 4'b0000, 4'b0010);
    cycle("lk_after", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    cycle("lk_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Owner drops req while locked: no grant that cycle.
    do_reset();
    ra[2] = 12'h070;
    cycle("own_lock", 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    cycle("own_drop", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    cycle("own_after", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    cycle("own_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Burst cap: 16 grants to requester 3, then requester 1.
    do_reset();
    ra[3] = 12'h080;
    ra[1] = 12'h090;
    cycle("cap_first", 4'b1000, 4'b0000, 4'b1000, 4'b1000);
    for (int i = 0; i < 15; i++)
      cycle("cap_beat", 4'b1010, 4'b0000, 4'b1000, 4'b1000);
    cycle("cap_release", 4'b1010, 4'b0000, 4'b1000, 4'b0010);
    cycle("cap_solo", 4'b1000, 4'b0000, 4'b1000, 4'b1000);
    cycle("cap_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cycle("cap_idle2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Reset in the middle of a locked read burst.
    do_reset();
    ra[2] = 12'h0A0;
    cycle("mb0", 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    cycle("mb1", 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    cycle("mb2", 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    rstn = 1'b0;
    req  = 4'b0000;
    lock = 4'b0000;
    sb.delete();
    #1;
    check("mb_rst_rd_valid", {60'd0, rd_valid}, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    ra[0] = 12'h0B0;
    cycle("post_rst0", 4'b0101, 4'b0000, 4'b0000, 4'b0001);
    cycle("post_rst2", 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    cycle("post_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cycle("post_idle2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
